if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline. It owns the program counter, reads instruction memory and predecodes the fetched word. It predicts the next PC: JAL and JALR are always taken, and conditional branches use a 16-entry 2-bit branch history table (BHT). It sits directly upstream of the IF/ID register and decode stage, and drives the register file's prediction read port to get the JALR base register.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_IDX_W, 4, BHT index width (2^BHT_IDX_W entries, index = pc[BHT_IDX_W+1:2]).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_if_i  in  1  hazard unit: hold PC.
- redirect_if_i  in  1  EX resolved a mispredict or jump; load redirect_pc_if_i.
- redirect_pc_if_i  in  32  corrected PC.
- bht_update_if_i  in  1  EX resolved a conditional branch.
- bht_update_pc_if_i  in  32  PC of the resolved branch.
- bht_taken_if_i  in  1  actual branch outcome.
- instr_mem_addr_if_o  out  32  equals pc.
- instr_mem_data_if_i  in  32  instruction at instr_mem_addr_if_o, combinational read.
- prediction_Rs1_if_o  out  5  instr[19:15], to the register-file prediction port.
- prediction_Rs1_data_if_i  in  32  register data returned for prediction_Rs1_if_o, combinational.
- pc_if_o  out  32  PC of the current fetch.
- instr_if_o  out  32  fetched instruction.
- predicted_taken_if_o  out  1  prediction for the current instruction.
- predicted_pc_if_o  out  32  predicted next PC, carried down the pipe for the EX compare.
- halted_if_o  out  1  fetch frozen on ECALL.

## Operation
- Predecode uses opcode instr[6:0]:
  - JAL 1101111: taken; target = pc + J-imm.
  - JALR 1100111: taken; target = (prediction_Rs1_data_if_i + I-imm) & ~32'h1.
  - BRANCH 1100011: taken iff BHT[idx][1]; target = pc + B-imm.
  - Any other opcode: not taken; target = pc + 4.
- All address arithmetic is 32-bit modulo 2^32; immediates are sign-extended.
- predicted_pc_if_o is the target when taken, otherwise pc + 4.
- Next-PC priority:
  1. reset
  2. redirect_if_i
  3. halted or stall_if_i (hold)
  4. predicted_pc_if_o
- BHT: 2-bit saturating counters, all reset to 2'b01 (weakly not taken). On bht_update_if_i, the entry indexed by bht_update_pc_if_i increments if taken and decrements otherwise, saturating at 2'b11 and 2'b00.
- Halt FSM has two states, RUN and HALT:
  - RUN to HALT when instr_if_o == 32'h0000_0073 and stall_if_i == 0 and redirect_if_i == 0.
  - HALT to RUN on redirect_if_i.
  - In HALT, PC holds, halted_if_o = 1, and predicted_taken_if_o = 0.
- The prediction port's data can be stale under a hazard. This is accepted: EX detects the mispredict and redirects.

## Timing
- Reset (async) sets pc = RESET_PC, all BHT entries = 2'b01, and the FSM to RUN. While reset is asserted, pc_if_o = RESET_PC and halted_if_o = 0; all other outputs are combinational from pc and instruction memory.
- PC update latency is one cycle. A redirect asserted in cycle N gives pc = redirect_pc_if_i from the N+1 edge, regardless of stall_if_i or HALT.
- A BHT update is registered. A same-cycle read of the entry being updated returns the old value; the new value is visible from the next cycle.
- Stall holds pc, but a BHT update still commits during stall.
- Reset asserted mid-run takes effect immediately. The first fetch after release is at RESET_PC.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - INSTR_ECALL = 32'h0000_0073
  - BHT_INIT = 2'b01
  - immediate-extraction functions (I, B, J), shared with decode
- Sub-module if_bht contains the counter array, combinational read port and registered saturating update. if_stage contains the PC register, predecode, next-PC mux and the halt FSM.

## Test plan
- Reset, then NOPs (32'h0000_0013): pc_if_o = 0 during reset, then 0x0, 0x4, 0x8 on successive cycles; predicted_taken_if_o = 0.
- JAL 32'h0100_006F at pc 0x10: predicted_taken_if_o = 1, predicted_pc_if_o = 0x20, next pc = 0x20.
- BEQ 32'hFE00_0CE3 at pc 0x20:
  - Fresh BHT: next pc 0x24.
  - After one bht_update (pc 0x20, taken): next pc 0x18.
  - After four not-taken updates: counter is 2'b00 and next pc is 0x24.
- JALR 32'h0000_8067 with prediction_Rs1_data_if_i = 0x105: prediction_Rs1_if_o = 1, next pc = 0x104.
- stall_if_i = 1 and redirect to 0x200 in the same cycle: pc = 0x200 next cycle. stall_if_i alone holds pc for 3 cycles.
- ECALL at pc 0x30: halted_if_o = 1 and pc holds at 0x30 for 10 cycles. Redirect to 0x0 releases the halt. Reset mid-halt gives pc = RESET_PC and halted_if_o = 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode constants and immediate decoders
// Purpose: constants and sign-extending immediate extraction used by fetch and decode.
// Contents: OP_JAL, OP_JALR, OP_BRANCH, INSTR_ECALL, BHT_INIT, imm_i(), imm_b(), imm_j().
package riscv_pkg;

  localparam logic [6:0]  OP_JAL      = 7'b1101111;
  localparam logic [6:0]  OP_JALR     = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [1:0]  BHT_INIT    = 2'b01;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_bht.sv
// rtl/if_bht.sv - branch history table of 2-bit saturating counters
// Purpose: combinational read of one counter, registered saturating update of another.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (all counters -> BHT_INIT)
//   rd_idx / rd_ctr   read index and counter value (old value on same-cycle update)
//   upd_en            commit an update this cycle
//   upd_idx           index of the counter to update
//   upd_taken         1 = increment toward 2'b11, 0 = decrement toward 2'b00
module if_bht
  import riscv_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] ctr_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      if (upd_taken && (ctr_q[upd_idx] != 2'b11)) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
      end else if (!upd_taken && (ctr_q[upd_idx] != 2'b00)) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch with predecode and next-PC prediction
// Purpose: owns the PC, predecodes the fetched word, predicts the next PC and halts on ECALL.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   stall_if_i                      hold PC
//   redirect_if_i/redirect_pc_if_i  load corrected PC (beats stall and halt)
//   bht_update_if_i/_pc/_taken      resolved conditional branch outcome
//   instr_mem_addr_if_o/_data_if_i  combinational instruction memory port
//   prediction_Rs1_if_o/_data_if_i  register-file read port for the JALR base
//   pc_if_o, instr_if_o             current fetch
//   predicted_taken_if_o/pc_if_o    prediction for the current fetch
//   halted_if_o                     fetch frozen on ECALL
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if_i,
  input  logic        redirect_if_i,
  input  logic [31:0] redirect_pc_if_i,
  input  logic        bht_update_if_i,
  input  logic [31:0] bht_update_pc_if_i,
  input  logic        bht_taken_if_i,
  output logic [31:0] instr_mem_addr_if_o,
  input  logic [31:0] instr_mem_data_if_i,
  output logic [4:0]  prediction_Rs1_if_o,
  input  logic [31:0] prediction_Rs1_data_if_i,
  output logic [31:0] pc_if_o,
  output logic [31:0] instr_if_o,
  output logic        predicted_taken_if_o,
  output logic [31:0] predicted_pc_if_o,
  output logic        halted_if_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0] pc_q;
  logic [0:0]  state_q;
  logic [1:0]  bht_ctr;
  logic [31:0] pc_plus4;
  logic        raw_taken;
  logic [31:0] raw_target;
  logic        ecall_seen;
  logic        hold_pc;

  if_bht #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr   (bht_ctr),
    .upd_en   (bht_update_if_i),
    .upd_idx  (bht_update_pc_if_i[BHT_IDX_W+1:2]),
    .upd_taken(bht_taken_if_i)
  );

  assign pc_plus4            = pc_q + 32'd4;
  assign instr_mem_addr_if_o = pc_q;
  assign pc_if_o             = pc_q;
  assign instr_if_o          = instr_mem_data_if_i;
  assign prediction_Rs1_if_o = instr_mem_data_if_i[19:15];
  assign halted_if_o         = (state_q == ST_HALT);

  always_comb begin
    raw_taken  = 1'b0;
    raw_target = pc_plus4;
    unique case (instr_mem_data_if_i[6:0])
      OP_JAL: begin
        raw_taken  = 1'b1;
        raw_target = pc_q + imm_j(instr_mem_data_if_i);
      end
      OP_JALR: begin
        raw_taken  = 1'b1;
        raw_target = (prediction_Rs1_data_if_i + imm_i(instr_mem_data_if_i)) & ~32'h1;
      end
      OP_BRANCH: begin
        raw_taken  = bht_ctr[1];
        raw_target = pc_q + imm_b(instr_mem_data_if_i);
      end
      default: begin
        raw_taken  = 1'b0;
        raw_target = pc_plus4;
      end
    endcase
  end

  assign predicted_taken_if_o = raw_taken && !halted_if_o;
  assign predicted_pc_if_o    = predicted_taken_if_o ? raw_target : pc_plus4;

  // An ECALL in RUN already freezes the PC on the edge that enters HALT, so the
  // halted PC is the ECALL's own address rather than the one after it.
  assign ecall_seen = (instr_mem_data_if_i == INSTR_ECALL);
  assign hold_pc    = halted_if_o || stall_if_i || ecall_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_if_i) begin
      pc_q <= redirect_pc_if_i;
    end else if (!hold_pc) begin
      pc_q <= predicted_pc_if_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ecall_seen && !stall_if_i && !redirect_if_i) begin
            state_q <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (redirect_if_i) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if_i;
  logic        redirect_if_i;
  logic [31:0] redirect_pc_if_i;
  logic        bht_update_if_i;
  logic [31:0] bht_update_pc_if_i;
  logic        bht_taken_if_i;
  logic [31:0] instr_mem_addr_if_o;
  logic [31:0] instr_mem_data_if_i;
  logic [4:0]  prediction_Rs1_if_o;
  logic [31:0] prediction_Rs1_data_if_i;
  logic [31:0] pc_if_o;
  logic [31:0] instr_if_o;
  logic        predicted_taken_if_o;
  logic [31:0] predicted_pc_if_o;
  logic        halted_if_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  int          m_bht [16];
  bit          m_halt;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  if_stage dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .stall_if_i              (stall_if_i),
    .redirect_if_i           (redirect_if_i),
    .redirect_pc_if_i        (redirect_pc_if_i),
    .bht_update_if_i         (bht_update_if_i),
    .bht_update_pc_if_i      (bht_update_pc_if_i),
    .bht_taken_if_i          (bht_taken_if_i),
    .instr_mem_addr_if_o     (instr_mem_addr_if_o),
    .instr_mem_data_if_i     (instr_mem_data_if_i),
    .prediction_Rs1_if_o     (prediction_Rs1_if_o),
    .prediction_Rs1_data_if_i(prediction_Rs1_data_if_i),
    .pc_if_o                 (pc_if_o),
    .instr_if_o              (instr_if_o),
    .predicted_taken_if_o    (predicted_taken_if_o),
    .predicted_pc_if_o       (predicted_pc_if_o),
    .halted_if_o             (halted_if_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  // Called just after a rising edge; drives one cycle, checks it, advances the model.
  task automatic step(input logic [31:0] ins, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic up, input logic [31:0] upc,
                      input logic tk, input logic [31:0] rs1d);
    int          imm;
    logic [31:0] target;
    logic        taken;
    logic [31:0] exp_ppc;
    int          idx;
    instr_mem_data_if_i      = ins;
    stall_if_i               = st;
    redirect_if_i            = rd;
    redirect_pc_if_i         = rpc;
    bht_update_if_i          = up;
    bht_update_pc_if_i       = upc;
    bht_taken_if_i           = tk;
    prediction_Rs1_data_if_i = rs1d;
    #2;
    taken  = 1'b0;
    target = m_pc + 32'd4;
    if (ins[6:0] == 7'b1101111) begin
      imm    = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
             + int'(ins[30:21]) * 2;
      taken  = 1'b1;
      target = m_pc + 32'(imm);
    end else if (ins[6:0] == 7'b1100111) begin
      imm    = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
      taken  = 1'b1;
      target = (rs1d + 32'(imm)) & 32'hFFFF_FFFE;
    end else if (ins[6:0] == 7'b1100011) begin
      imm    = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
             + int'(ins[11:8]) * 2;
      taken  = (m_bht[(m_pc / 4) % 16] >= 2);
      target = m_pc + 32'(imm);
    end
    if (m_halt) taken = 1'b0;
    exp_ppc = taken ? target : m_pc + 32'd4;
    chk("pc", pc_if_o, m_pc);
    chk("imem_addr", instr_mem_addr_if_o, m_pc);
    chk("instr", instr_if_o, ins);
    chk("rs1", {27'h0, prediction_Rs1_if_o}, {27'h0, ins[19:15]});
    chk("pred_taken", {31'h0, predicted_taken_if_o}, {31'h0, taken});
    chk("pred_pc", predicted_pc_if_o, exp_ppc);
    chk("halted", {31'h0, halted_if_o}, {31'h0, m_halt});
    @(posedge clk);
    if (rd) begin
      m_pc   = rpc;
      m_halt = 1'b0;
    end else if (m_halt || st) begin
      m_pc = m_pc;
    end else if (ins == ECALL) begin
      m_halt = 1'b1;
    end else begin
      m_pc = exp_ppc;
    end
    if (up) begin
      idx = (upc / 4) % 16;
      if (tk && m_bht[idx] < 3) m_bht[idx]++;
      else if (!tk && m_bht[idx] > 0) m_bht[idx]--;
    end
    #1;
  endtask

  task automatic run(input logic [31:0] ins);
    step(ins, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] ins, input logic [31:0] rpc);
    step(ins, 1'b0, 1'b1, rpc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] ins;
    int          sel;
    rst_n                    = 1'b0;
    stall_if_i               = 1'b0;
    redirect_if_i            = 1'b0;
    redirect_pc_if_i         = 32'h0;
    bht_update_if_i          = 1'b0;
    bht_update_pc_if_i       = 32'h0;
    bht_taken_if_i           = 1'b0;
    instr_mem_data_if_i      = NOP;
    prediction_Rs1_data_if_i = 32'h0;
    model_reset();
    #1;
    chk("reset_pc", pc_if_o, 32'h0);
    chk("reset_halted", {31'h0, halted_if_o}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // NOPs from RESET_PC
    run(NOP);
    chk("nop_pc4", pc_if_o, 32'h4);
    run(NOP);
    chk("nop_pc8", pc_if_o, 32'h8);
    run(NOP);
    run(NOP);

    // JAL at 0x10
    run(32'h0100_006F);
    chk("jal_next", pc_if_o, 32'h20);

    // BEQ at 0x20: fresh BHT, same-cycle taken update still reads the old counter
    step(32'hFE00_0CE3, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h0);
    chk("beq_fresh", pc_if_o, 32'h24);
    redirect(NOP, 32'h20);
    run(32'hFE00_0CE3);
    chk("beq_taken", pc_if_o, 32'h18);
    for (int i = 0; i < 4; i++) begin
      step(NOP, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0);
    end
    chk("stall_bht_pc", pc_if_o, 32'h18);
    redirect(NOP, 32'h20);
    run(32'hFE00_0CE3);
    chk("beq_sat_low", pc_if_o, 32'h24);

    // JALR x1 at 0x24
    step(32'h0000_8067, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h105);
    chk("jalr_next", pc_if_o, 32'h104);

    // stall + redirect in the same cycle, then stall alone
    step(NOP, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_redirect", pc_if_o, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step(NOP, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_hold", pc_if_o, 32'h200);
    end

    // ECALL halt and release
    redirect(NOP, 32'h30);
    for (int i = 0; i < 10; i++) begin
      run(ECALL);
      chk("halt_pc", pc_if_o, 32'h30);
      chk("halt_flag", {31'h0, halted_if_o}, 32'h1);
    end
    redirect(ECALL, 32'h0);
    chk("unhalt_pc", pc_if_o, 32'h0);
    chk("unhalt_flag", {31'h0, halted_if_o}, 32'h0);

    // reset in the middle of a halt
    redirect(NOP, 32'h30);
    run(ECALL);
    run(ECALL);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("midreset_pc", pc_if_o, 32'h0);
    chk("midreset_halted", {31'h0, halted_if_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(NOP);
    chk("post_reset_pc", pc_if_o, 32'h4);

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      w   = $urandom;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    ins = {w[31:7], 7'b1101111};
        2, 3:    ins = {w[31:7], 7'b1100111};
        4, 5, 6: ins = {w[31:7], 7'b1100011};
        7:       ins = ECALL;
        8:       ins = w;
        default: ins = NOP;
      endcase
      step(ins,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0),
           $urandom & 32'h0000_0FFC,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1) ? m_pc : $urandom,
           $urandom_range(0, 1) == 1,
           $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
